mem_responder: RTL and testbench

- Word-granular backing-memory model. Sits at the far end of the cache's external memory interface and answers the cache's `o_mem_*` requests.
- One instance serves the instruction cache and one serves the data cache, in both the simulation top and the FPGA top.
- Holds an internal word array and services one request at a time with a fixed, parameterised latency.
- Raises a sticky error flag on protocol violations, so benches can catch initiator bugs.

---
 rtl/mem_responder.sv | 115 +++++++++++
 tb/tb_mem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-granular backing memory answering a cache's external memory requests
// with a fixed, parameterised latency and a sticky protocol-violation flag.
module mem_responder #(
  parameter int    ADDR_W    = 10,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_ready,
  input  logic [31:0] i_mem_addr,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_valid,
  output logic        o_err
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "mem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [31:0]       mem [2**ADDR_W];
  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, cur_idx, rd_idx;
  logic              pend_read;
  logic              load_rdata;
  logic              accept, viol;
  logic [31:0]       rdata_q;
  logic              err_q;

  // Byte offset and bits above the index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{i_mem_addr[31:ADDR_W+2], i_mem_addr[1:0]};

  assign cur_idx     = i_mem_addr[ADDR_W+1:2];
  assign o_mem_ready = (state != S_WAIT);
  assign o_mem_valid = (state == S_RESP);
  assign o_mem_rdata = rdata_q;
  assign o_err       = err_q;

  assign accept = o_mem_ready && (i_mem_ren ^ i_mem_wen);
  assign viol   = (i_mem_ren && i_mem_wen) ||
                  ((i_mem_ren || i_mem_wen) && !o_mem_ready);

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    load_rdata = 1'b0;
    rd_idx     = cur_idx;
    case (state)
      S_IDLE, S_RESP: begin
        if (state == S_RESP) state_d = S_IDLE;
        if (accept) begin
          if (LATENCY == 1) begin
            state_d    = i_mem_ren ? S_RESP : S_IDLE;
            load_rdata = i_mem_ren;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        rd_idx = addr_q;
        if (cnt == 4'd1) begin
          cnt_d      = '0;
          state_d    = pend_read ? S_RESP : S_IDLE;
          load_rdata = pend_read;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      pend_read <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        addr_q    <= cur_idx;
        pend_read <= i_mem_ren;
      end
      if (load_rdata) rdata_q <= mem[rd_idx];
      err_q <= err_q | viol;
    end
  end

  // Array is not reset; writes land at the acceptance edge.
  always_ff @(posedge i_clk) begin
    if (accept && i_mem_wen) mem[cur_idx] <= i_mem_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=4 instance and LATENCY=1 instance.
module tb_mem_responder;

  logic clk;
  int   n_pass = 0;
  int   n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        a_rst_n, a_ready, a_ren, a_wen, a_valid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_rst_n, b_ready, b_ren, b_wen, b_valid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;

  mem_responder #(.ADDR_W(10), .LATENCY(4), .INIT_FILE("")) u_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .o_mem_ready(a_ready),
    .i_mem_addr(a_addr), .i_mem_ren(a_ren), .i_mem_wen(a_wen),
    .i_mem_wdata(a_wdata), .o_mem_rdata(a_rdata), .o_mem_valid(a_valid),
    .o_err(a_err)
  );

  mem_responder #(.ADDR_W(10), .LATENCY(1), .INIT_FILE("")) u_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .o_mem_ready(b_ready),
    .i_mem_addr(b_addr), .i_mem_ren(b_ren), .i_mem_wen(b_wen),
    .i_mem_wdata(b_wdata), .o_mem_rdata(b_rdata), .o_mem_valid(b_valid),
    .o_err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Write on instance A and wait out the LATENCY-1 busy cycles.
  task automatic a_write(input logic [31:0] addr, input logic [31:0] data);
    a_addr = addr; a_wdata = data; a_wen = 1'b1;
    tick();
    a_wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_busy_ready", {31'd0, a_ready}, 32'd0);
      chk("wr_no_valid", {31'd0, a_valid}, 32'd0);
      tick();
    end
    chk("wr_done_ready", {31'd0, a_ready}, 32'd1);
  endtask

  // Read on instance A: accept, then check busy cycles and the response cycle.
  task automatic a_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a_addr = addr; a_ren = 1'b1;
    tick();
    a_ren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy_ready"}, {31'd0, a_ready}, 32'd0);
      chk({tag, "_busy_valid"}, {31'd0, a_valid}, 32'd0);
      tick();
    end
    chk({tag, "_valid"}, {31'd0, a_valid}, 32'd1);
    chk({tag, "_ready"}, {31'd0, a_ready}, 32'd1);
    chk({tag, "_rdata"}, a_rdata, exp);
  endtask

  logic [31:0] fill [4];

  initial begin
    a_rst_n = 1'b0; a_ren = 1'b0; a_wen = 1'b0; a_addr = '0; a_wdata = '0;
    b_rst_n = 1'b0; b_ren = 1'b0; b_wen = 1'b0; b_addr = '0; b_wdata = '0;
    fill[0] = 32'h1111_0000; fill[1] = 32'h2222_0001;
    fill[2] = 32'h3333_0002; fill[3] = 32'h4444_0003;
    tick(); tick();

    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    a_rst_n = 1'b1;
    tick();

    // Read latency and write-then-read
    a_write(32'h0000_000C, 32'hDEAD_BEEF);
    a_read("lat4", 32'h0000_000C, 32'hDEAD_BEEF);
    tick();
    chk("lat4_after_valid", {31'd0, a_valid}, 32'd0);
    chk("lat4_rdata_hold", a_rdata, 32'hDEAD_BEEF);

    a_write(32'h0000_0040, 32'h1234_5678);
    a_read("wr_rd", 32'h0000_0040, 32'h1234_5678);
    chk("wr_rd_err", {31'd0, a_err}, 32'd0);
    tick();

    // Aliasing: 0x1000 maps onto word 0
    a_write(32'h0000_0000, 32'hA11A_5000);
    a_read("alias", 32'h0000_1000, 32'hA11A_5000);
    tick();

    // Line fill, each read issued in the RESP cycle of the previous one
    for (int i = 0; i < 4; i++) a_write(32'h0000_0100 + 32'(4 * i), fill[i]);
    a_addr = 32'h0000_0100; a_ren = 1'b1;
    tick();
    a_ren = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_gap_valid", {31'd0, a_valid}, 32'd0);
      tick(); tick();
      chk("fill_valid", {31'd0, a_valid}, 32'd1);
      chk("fill_rdata", a_rdata, fill[i]);
      if (i < 3) begin
        a_addr = 32'h0000_0100 + 32'(4 * (i + 1)); a_ren = 1'b1;
        tick();
        a_ren = 1'b0;
      end
    end
    tick();
    chk("fill_err", {31'd0, a_err}, 32'd0);

    // ren and wen together: flagged, ignored
    a_addr = 32'h0000_0040; a_wdata = 32'h0BAD_0BAD; a_ren = 1'b1; a_wen = 1'b1;
    tick();
    a_ren = 1'b0; a_wen = 1'b0;
    chk("both_err", {31'd0, a_err}, 32'd1);
    chk("both_ready", {31'd0, a_ready}, 32'd1);
    chk("both_valid", {31'd0, a_valid}, 32'd0);
    a_read("both_unchanged", 32'h0000_0040, 32'h1234_5678);
    tick();

    // Request during WAIT: flagged, original response on time
    a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1;
    chk("rst2_err", {31'd0, a_err}, 32'd0);
    a_addr = 32'h0000_000C; a_ren = 1'b1;
    tick();
    a_addr = 32'h0000_0040;
    tick();
    a_ren = 1'b0;
    chk("busy_req_err", {31'd0, a_err}, 32'd1);
    tick(); tick();
    chk("busy_req_valid", {31'd0, a_valid}, 32'd1);
    chk("busy_req_rdata", a_rdata, 32'hDEAD_BEEF);
    tick();

    // Asynchronous reset two cycles into a read
    a_addr = 32'h0000_0040; a_ren = 1'b1;
    tick();
    a_ren = 1'b0;
    tick(); tick();
    #2 a_rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, a_ready}, 32'd1);
    chk("arst_valid", {31'd0, a_valid}, 32'd0);
    chk("arst_rdata", a_rdata, 32'd0);
    chk("arst_err", {31'd0, a_err}, 32'd0);
    tick();
    a_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("arst_no_valid", {31'd0, a_valid}, 32'd0);
      tick();
    end
    a_read("arst_next", 32'h0000_000C, 32'hDEAD_BEEF);
    tick();

    // LATENCY=1: back-to-back writes then reads on consecutive edges
    b_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_addr = 32'h0000_0200 + 32'(4 * i);
      b_wdata = 32'hB000_0000 + 32'(17 * i);
      b_wen = 1'b1;
      tick();
      chk("l1_wr_ready", {31'd0, b_ready}, 32'd1);
      chk("l1_wr_valid", {31'd0, b_valid}, 32'd0);
    end
    b_wen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_addr = 32'h0000_0200 + 32'(4 * i);
      b_ren = 1'b1;
      tick();
      chk("l1_rd_ready", {31'd0, b_ready}, 32'd1);
      chk("l1_rd_valid", {31'd0, b_valid}, 32'd1);
      chk("l1_rd_rdata", b_rdata, 32'hB000_0000 + 32'(17 * i));
    end
    b_ren = 1'b0;
    tick();
    chk("l1_end_valid", {31'd0, b_valid}, 32'd0);
    chk("l1_err", {31'd0, b_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
